// File: rtl/lu_pkg.sv
// Shared types and sizing for the LU matrix bank store.
// LU_ROW_W(size, width) gives the packed row width: size complex elements of {imag, real}.
`define LU_ROW_W(size, width) ((size) * 2 * (width))

package lu_pkg;

  localparam int unsigned LU_SIZE  = 16;
  localparam int unsigned LU_WIDTH = 64;
  localparam int unsigned ROW_W    = `LU_ROW_W(LU_SIZE, LU_WIDTH);
  localparam int unsigned ADDR_W   = $clog2(LU_SIZE);

  typedef enum logic [2:0] {
    EMPTY   = 3'd0,
    LOADING = 3'd1,
    FULL    = 3'd2,
    BUSY    = 3'd3,
    DONE    = 3'd4
  } bank_state_e;

  typedef struct packed {
    logic [LU_WIDTH-1:0] imag;
    logic [LU_WIDTH-1:0] re;
  } cplx_t;

endpackage

// File: rtl/lu_rd_pipe.sv
// Fixed-latency valid/data delay line used behind both array read ports.
module lu_rd_pipe
#(
  parameter int unsigned DW  = 8,
  parameter int unsigned LAT = 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          flush_i,
  input  logic          valid_i,
  input  logic [DW-1:0] data_i,
  output logic          valid_o,
  output logic [DW-1:0] data_o
);

  if (LAT < 1) begin : g_bad_lat
    $error("lu_rd_pipe: LAT must be at least 1");
  end

  logic [LAT-1:0] vld_q;
  logic [DW-1:0]  dat_q [LAT];

  // Shift register; flush drops anything still in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_q <= '0;
      for (int i = 0; i < LAT; i++) dat_q[i] <= '0;
    end else if (flush_i) begin
      vld_q <= '0;
      for (int i = 0; i < LAT; i++) dat_q[i] <= '0;
    end else begin
      vld_q[0] <= valid_i;
      dat_q[0] <= data_i;
      for (int i = 1; i < LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        dat_q[i] <= dat_q[i-1];
      end
    end
  end

  assign valid_o = vld_q[LAT-1];
  assign data_o  = dat_q[LAT-1];

endmodule

// File: rtl/lu_mat_bank.sv
// Multi-bank complex matrix store between host and LU engine (load -> engine -> drain rotation).
// Optional zero-pivot detection on load is enabled by defining LU_BANK_PIVOT_CHK_EN.
module lu_mat_bank
  import lu_pkg::*;
#(
  parameter int unsigned SIZE      = 16,
  parameter int unsigned WIDTH     = 64,
  parameter int unsigned NUM_BANKS = 2,
  parameter int unsigned RD_LAT    = 1
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic                                flush_i,
  input  logic [`LU_ROW_W(SIZE, WIDTH)-1:0]   ld_row_i,
  input  logic [$clog2(SIZE)-1:0]             ld_addr_i,
  input  logic                                ld_valid_i,
  input  logic                                ld_last_i,
  output logic                                ld_ready_o,
  output logic                                start_o,
  input  logic                                engine_ready_i,
  input  logic                                done_i,
  input  logic [$clog2(SIZE)-1:0]             rd_addr_i,
  input  logic                                rd_addr_valid_i,
  output logic [`LU_ROW_W(SIZE, WIDTH)-1:0]   rd_row_o,
  output logic [$clog2(SIZE)-1:0]             rd_addr_o,
  output logic                                rd_row_valid_o,
  input  logic [`LU_ROW_W(SIZE, WIDTH)-1:0]   wr_row_i,
  input  logic [$clog2(SIZE)-1:0]             wr_addr_i,
  input  logic                                wr_valid_i,
  input  logic [`LU_ROW_W(SIZE, WIDTH)-1:0]   res_l_col_i,
  input  logic [`LU_ROW_W(SIZE, WIDTH)-1:0]   res_u_row_i,
  input  logic [$clog2(SIZE)-1:0]             res_addr_i,
  input  logic                                res_valid_i,
  input  logic                                out_req_i,
  input  logic                                out_sel_i,
  input  logic [$clog2(SIZE)-1:0]             out_addr_i,
  input  logic                                out_last_i,
  output logic [`LU_ROW_W(SIZE, WIDTH)-1:0]   out_row_o,
  output logic                                out_valid_o,
  output logic                                out_avail_o,
  output logic                                busy_o,
`ifdef LU_BANK_PIVOT_CHK_EN
  output logic                                pivot_zero_o,
`endif
  output logic                                err_o
);

  localparam int unsigned RW = `LU_ROW_W(SIZE, WIDTH);
  localparam int unsigned AW = $clog2(SIZE);

  if (NUM_BANKS < 1 || NUM_BANKS > 2) begin : g_bad_banks
    $error("lu_mat_bank: NUM_BANKS must be 1 or 2");
  end

  function automatic logic [0:0] nxt_ptr(input logic [0:0] p);
    return (NUM_BANKS == 2) ? ~p : 1'b0;
  endfunction

  bank_state_e st_q [NUM_BANKS];
  bank_state_e st_d [NUM_BANKS];
  logic [0:0]  ld_ptr_q, ld_ptr_d, eng_ptr_q, eng_ptr_d, dr_ptr_q, dr_ptr_d;
  logic        ld_ready_q, ld_ready_d, avail_q, avail_d, busy_q, busy_d, err_q, err_d;
  logic        ld_acc_s, eng_ok_s, done_acc_s, dr_acc_s, dr_last_s, any_busy_s, start_s;

  logic [RW-1:0] mat_q [NUM_BANKS][SIZE];
  logic [RW-1:0] l_q   [NUM_BANKS][SIZE];
  logic [RW-1:0] u_q   [NUM_BANKS][SIZE];
  logic [RW-1:0] eng_rd_s, dr_rd_s;
  logic [AW+RW-1:0] eng_pipe_s;

  assign ld_acc_s   = ld_valid_i & ld_ready_q;
  assign eng_ok_s   = (st_q[eng_ptr_q] == BUSY);
  assign done_acc_s = done_i & eng_ok_s;
  assign dr_acc_s   = out_req_i & avail_q;
  assign dr_last_s  = dr_acc_s & out_last_i;

  // State register: bank states, rotation pointers and registered status outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int b = 0; b < NUM_BANKS; b++) st_q[b] <= EMPTY;
      ld_ptr_q   <= 1'b0;
      eng_ptr_q  <= 1'b0;
      dr_ptr_q   <= 1'b0;
      ld_ready_q <= 1'b0;
      avail_q    <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      for (int b = 0; b < NUM_BANKS; b++) st_q[b] <= st_d[b];
      ld_ptr_q   <= ld_ptr_d;
      eng_ptr_q  <= eng_ptr_d;
      dr_ptr_q   <= dr_ptr_d;
      ld_ready_q <= ld_ready_d;
      avail_q    <= avail_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
    end
  end

  // Next state: each bank can only be at one lifecycle stage, so the event chain never collides.
  always_comb begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (flush_i) st_d[b] = EMPTY;
      else if (dr_last_s && int'(dr_ptr_q) == b) st_d[b] = EMPTY;
      else if (done_acc_s && int'(eng_ptr_q) == b) st_d[b] = DONE;
      else if (start_s && int'(eng_ptr_q) == b) st_d[b] = BUSY;
      else if (ld_acc_s && int'(ld_ptr_q) == b) st_d[b] = ld_last_i ? FULL : LOADING;
      else st_d[b] = st_q[b];
    end
    ld_ptr_d  = flush_i ? 1'b0 : ((ld_acc_s && ld_last_i) ? nxt_ptr(ld_ptr_q) : ld_ptr_q);
    eng_ptr_d = flush_i ? 1'b0 : (done_acc_s ? nxt_ptr(eng_ptr_q) : eng_ptr_q);
    dr_ptr_d  = flush_i ? 1'b0 : (dr_last_s ? nxt_ptr(dr_ptr_q) : dr_ptr_q);
    err_d     = flush_i ? 1'b0 :
                (err_q | ((wr_valid_i | res_valid_i | done_i) & ~eng_ok_s)
                       | (ld_valid_i & ~ld_ready_q) | (out_req_i & ~avail_q));
  end

  // Outputs: start is decided from the current state; status flags are precomputed for the next cycle.
  always_comb begin
    any_busy_s = 1'b0;
    busy_d     = 1'b0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      any_busy_s = any_busy_s | (st_q[b] == BUSY);
      busy_d     = busy_d | (st_d[b] != EMPTY);
    end
    start_s    = (st_q[eng_ptr_q] == FULL) & engine_ready_i & ~any_busy_s;
    ld_ready_d = (st_d[ld_ptr_d] == EMPTY) | (st_d[ld_ptr_d] == LOADING);
    avail_d    = (st_d[dr_ptr_d] == DONE);
  end

  // Matrix, L and U storage; contents deliberately survive reset and flush.
  always_ff @(posedge clk_i) begin
    if (ld_acc_s) mat_q[ld_ptr_q][ld_addr_i] <= ld_row_i;
    if (wr_valid_i && eng_ok_s) mat_q[eng_ptr_q][wr_addr_i] <= wr_row_i;
    if (res_valid_i && eng_ok_s) begin
      l_q[eng_ptr_q][res_addr_i] <= res_l_col_i;
      u_q[eng_ptr_q][res_addr_i] <= res_u_row_i;
    end
  end

  assign eng_rd_s = mat_q[eng_ptr_q][rd_addr_i];
  assign dr_rd_s  = out_sel_i ? u_q[dr_ptr_q][out_addr_i] : l_q[dr_ptr_q][out_addr_i];

  lu_rd_pipe #(.DW(AW + RW), .LAT(RD_LAT)) u_eng_pipe (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (flush_i),
    .valid_i (rd_addr_valid_i),
    .data_i  ({rd_addr_i, eng_rd_s}),
    .valid_o (rd_row_valid_o),
    .data_o  (eng_pipe_s)
  );

  lu_rd_pipe #(.DW(RW), .LAT(RD_LAT)) u_dr_pipe (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (flush_i),
    .valid_i (dr_acc_s),
    .data_i  (dr_rd_s),
    .valid_o (out_valid_o),
    .data_o  (out_row_o)
  );

  assign rd_addr_o   = eng_pipe_s[AW+RW-1:RW];
  assign rd_row_o    = eng_pipe_s[RW-1:0];
  assign start_o     = start_s;
  assign ld_ready_o  = ld_ready_q;
  assign out_avail_o = avail_q;
  assign busy_o      = busy_q;
  assign err_o       = err_q;

`ifdef LU_BANK_PIVOT_CHK_EN
  logic [NUM_BANKS-1:0] piv_q, piv_d;
  logic [2*WIDTH-1:0]   diag_s;
  logic                 diag_zero_s;

  // Sign bits are ignored so that -0.0 also counts as a zero pivot.
  assign diag_s      = ld_row_i[int'(ld_addr_i)*2*WIDTH +: 2*WIDTH];
  assign diag_zero_s = (diag_s[WIDTH-2:0] == '0) && (diag_s[2*WIDTH-2:WIDTH] == '0);

  // Per-bank sticky flag, cleared whenever the bank is (or returns to) EMPTY.
  always_comb begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (st_d[b] == EMPTY) piv_d[b] = 1'b0;
      else if (ld_acc_s && int'(ld_ptr_q) == b && diag_zero_s) piv_d[b] = 1'b1;
      else piv_d[b] = piv_q[b];
    end
  end

  // Pivot flag register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) piv_q <= '0;
    else         piv_q <= piv_d;
  end

  assign pivot_zero_o = piv_q[eng_ptr_q];
`endif

endmodule

// File: tb/tb_lu_mat_bank.sv
// Scoreboard bench for lu_mat_bank: one RD_LAT=1 instance and one RD_LAT=3 instance share all inputs.
module tb_lu_mat_bank;

  localparam int SIZE  = 16;
  localparam int WIDTH = 64;
  localparam int RW    = SIZE * 2 * WIDTH;
  localparam int AW    = 4;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [RW-1:0] row;
  } rd_exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic          flush_i, ld_valid_i, ld_last_i, engine_ready_i, done_i, rd_addr_valid_i;
  logic          wr_valid_i, res_valid_i, out_req_i, out_sel_i, out_last_i;
  logic [RW-1:0] ld_row_i, wr_row_i, res_l_col_i, res_u_row_i;
  logic [AW-1:0] ld_addr_i, rd_addr_i, wr_addr_i, res_addr_i, out_addr_i;

  logic          ld_ready_o, start_o, rd_row_valid_o, out_valid_o, out_avail_o, busy_o, err_o;
  logic [RW-1:0] rd_row_o, out_row_o;
  logic [AW-1:0] rd_addr_o;
  logic          ld_ready3, start3, rd_vld3, out_vld3, avail3, busy3, err3;
  logic [RW-1:0] rd_row3, out_row3;
  logic [AW-1:0] rd_addr3;
`ifdef LU_BANK_PIVOT_CHK_EN
  logic          pivot_zero_o, pivot3;
`endif

  lu_mat_bank #(.SIZE(SIZE), .WIDTH(WIDTH), .NUM_BANKS(2), .RD_LAT(1)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush_i),
    .ld_row_i(ld_row_i), .ld_addr_i(ld_addr_i), .ld_valid_i(ld_valid_i), .ld_last_i(ld_last_i),
    .ld_ready_o(ld_ready_o), .start_o(start_o), .engine_ready_i(engine_ready_i), .done_i(done_i),
    .rd_addr_i(rd_addr_i), .rd_addr_valid_i(rd_addr_valid_i), .rd_row_o(rd_row_o),
    .rd_addr_o(rd_addr_o), .rd_row_valid_o(rd_row_valid_o),
    .wr_row_i(wr_row_i), .wr_addr_i(wr_addr_i), .wr_valid_i(wr_valid_i),
    .res_l_col_i(res_l_col_i), .res_u_row_i(res_u_row_i), .res_addr_i(res_addr_i), .res_valid_i(res_valid_i),
    .out_req_i(out_req_i), .out_sel_i(out_sel_i), .out_addr_i(out_addr_i), .out_last_i(out_last_i),
    .out_row_o(out_row_o), .out_valid_o(out_valid_o), .out_avail_o(out_avail_o), .busy_o(busy_o),
`ifdef LU_BANK_PIVOT_CHK_EN
    .pivot_zero_o(pivot_zero_o),
`endif
    .err_o(err_o)
  );

  lu_mat_bank #(.SIZE(SIZE), .WIDTH(WIDTH), .NUM_BANKS(2), .RD_LAT(3)) u_dut3 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush_i),
    .ld_row_i(ld_row_i), .ld_addr_i(ld_addr_i), .ld_valid_i(ld_valid_i), .ld_last_i(ld_last_i),
    .ld_ready_o(ld_ready3), .start_o(start3), .engine_ready_i(engine_ready_i), .done_i(done_i),
    .rd_addr_i(rd_addr_i), .rd_addr_valid_i(rd_addr_valid_i), .rd_row_o(rd_row3),
    .rd_addr_o(rd_addr3), .rd_row_valid_o(rd_vld3),
    .wr_row_i(wr_row_i), .wr_addr_i(wr_addr_i), .wr_valid_i(wr_valid_i),
    .res_l_col_i(res_l_col_i), .res_u_row_i(res_u_row_i), .res_addr_i(res_addr_i), .res_valid_i(res_valid_i),
    .out_req_i(out_req_i), .out_sel_i(out_sel_i), .out_addr_i(out_addr_i), .out_last_i(out_last_i),
    .out_row_o(out_row3), .out_valid_o(out_vld3), .out_avail_o(avail3), .busy_o(busy3),
`ifdef LU_BANK_PIVOT_CHK_EN
    .pivot_zero_o(pivot3),
`endif
    .err_o(err3)
  );

  int checks = 0;
  int errors = 0;
  logic [RW-1:0] mdl_mat [2][SIZE];
  logic [RW-1:0] mdl_l   [2][SIZE];
  logic [RW-1:0] mdl_u   [2][SIZE];
  rd_exp_t       sb_q[$];
  rd_exp_t       sb3_q[$];
  logic [RW-1:0] out_q[$];

  function automatic logic [RW-1:0] make_row(input int mtx, input int r);
    logic [RW-1:0] v;
    for (int e = 0; e < SIZE; e++) begin
      v[e*2*WIDTH +: WIDTH]         = {16'(mtx + 1), 16'(r), 16'(e), 16'h5a5a};
      v[e*2*WIDTH + WIDTH +: WIDTH] = {16'(mtx + 1), 16'(r), 16'(e), 16'hc3c3};
    end
    return v;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    flush_i = 1'b0; ld_valid_i = 1'b0; ld_last_i = 1'b0; engine_ready_i = 1'b0; done_i = 1'b0;
    rd_addr_valid_i = 1'b0; wr_valid_i = 1'b0; res_valid_i = 1'b0; out_req_i = 1'b0;
    out_sel_i = 1'b0; out_last_i = 1'b0;
    ld_row_i = '0; wr_row_i = '0; res_l_col_i = '0; res_u_row_i = '0;
    ld_addr_i = '0; rd_addr_i = '0; wr_addr_i = '0; res_addr_i = '0; out_addr_i = '0;
  endtask

  task automatic drive_load(input int bank, input int mtx, output int not_rdy);
    not_rdy = 0;
    for (int r = 0; r < SIZE; r++) begin
      ld_valid_i = 1'b1; ld_addr_i = AW'(r); ld_row_i = make_row(mtx, r); ld_last_i = (r == SIZE - 1);
      if (ld_ready_o !== 1'b1) not_rdy++;
      mdl_mat[bank][r] = make_row(mtx, r);
      tick();
    end
    ld_valid_i = 1'b0; ld_last_i = 1'b0;
  endtask

  task automatic test_reset;
    idle_inputs();
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({ld_ready_o, start_o, busy_o, err_o, rd_row_valid_o, out_valid_o, out_avail_o} !== 7'b0)
      begin errors++; $display("FAIL reset_flags got=%b exp=0", {ld_ready_o, start_o, busy_o, err_o, rd_row_valid_o, out_valid_o, out_avail_o}); end
    checks++;
    if (rd_row_o !== '0 || out_row_o !== '0 || rd_addr_o !== '0)
      begin errors++; $display("FAIL reset_data rd=%h out=%h", rd_row_o[63:0], out_row_o[63:0]); end
    rst_n = 1'b1;
    #1;
    checks++;
    if (ld_ready_o !== 1'b0) begin errors++; $display("FAIL ld_ready_early got=%b exp=0", ld_ready_o); end
    @(negedge clk);
    checks++;
    if (ld_ready_o !== 1'b1) begin errors++; $display("FAIL ld_ready_rise got=%b exp=1", ld_ready_o); end
    tick();
  endtask

  task automatic test_load_start;
    int nr, cnt, lat;
    rd_exp_t e;
    drive_load(0, 0, nr);
    checks++;
    if (nr !== 0) begin errors++; $display("FAIL load_a_ready not_ready_beats=%0d exp=0", nr); end
    @(negedge clk);
    checks++;
    if (start_o !== 1'b0 || busy_o !== 1'b1) begin errors++; $display("FAIL full_wait start=%b busy=%b exp 0/1", start_o, busy_o); end
    tick();
    engine_ready_i = 1'b1;
    cnt = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (start_o === 1'b1) cnt++;
      tick();
    end
    engine_ready_i = 1'b0;
    checks++;
    if (cnt !== 1) begin errors++; $display("FAIL start_pulses got=%0d exp=1", cnt); end
    sb_q.push_back({AW'(3), mdl_mat[0][3]});
    rd_addr_i = AW'(3); rd_addr_valid_i = 1'b1;
    lat = -1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (rd_row_valid_o === 1'b1) begin
        checks++;
        if (sb_q.size() == 0) begin errors++; $display("FAIL rd3_extra got valid exp none"); end
        else begin
          e = sb_q.pop_front();
          if (rd_row_o !== e.row || rd_addr_o !== e.addr) begin
            errors++; $display("FAIL rd3_data addr got=%0d exp=%0d row got=%h exp=%h", rd_addr_o, e.addr, rd_row_o[63:0], e.row[63:0]);
          end
          lat = c;
        end
      end
      tick();
      rd_addr_valid_i = 1'b0;
    end
    checks++;
    if (lat !== 1 || sb_q.size() != 0) begin errors++; $display("FAIL rd3_latency got=%0d exp=1 left=%0d", lat, sb_q.size()); end
    sb_q.delete();
  endtask

  task automatic test_rw_collision;
    rd_exp_t e;
    logic [RW-1:0] pat;
    pat = {(RW/8){8'hA5}};
    for (int c = 0; c < 7; c++) begin
      if (c == 0) begin
        rd_addr_i = AW'(5); rd_addr_valid_i = 1'b1;
        wr_addr_i = AW'(5); wr_row_i = pat; wr_valid_i = 1'b1;
        sb_q.push_back({AW'(5), mdl_mat[0][5]});
        mdl_mat[0][5] = pat;
      end else if (c == 1) begin
        wr_valid_i = 1'b0;
        sb_q.push_back({AW'(5), mdl_mat[0][5]});
      end else begin
        rd_addr_valid_i = 1'b0;
      end
      @(negedge clk);
      if (rd_row_valid_o === 1'b1) begin
        checks++;
        if (sb_q.size() == 0) begin errors++; $display("FAIL rw_extra got valid exp none"); end
        else begin
          e = sb_q.pop_front();
          if (rd_row_o !== e.row || rd_addr_o !== e.addr) begin
            errors++; $display("FAIL rw_same_addr row got=%h exp=%h", rd_row_o[63:0], e.row[63:0]);
          end
        end
      end
      tick();
    end
    checks++;
    if (sb_q.size() != 0) begin errors++; $display("FAIL rw_timeout left=%0d exp=0", sb_q.size()); end
    sb_q.delete();
  endtask

  task automatic test_second_load;
    int nr, cnt;
    engine_ready_i = 1'b1;
    for (int k = 0; k < SIZE; k++) begin
      res_addr_i = AW'(k); res_l_col_i = make_row(10, k); res_u_row_i = make_row(20, k); res_valid_i = 1'b1;
      mdl_l[0][k] = make_row(10, k);
      mdl_u[0][k] = make_row(20, k);
      tick();
    end
    res_valid_i = 1'b0;
    drive_load(1, 1, nr);
    checks++;
    if (nr !== 0) begin errors++; $display("FAIL load_b_ready not_ready_beats=%0d exp=0", nr); end
    cnt = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (start_o === 1'b1) cnt++;
      tick();
    end
    checks++;
    if (cnt !== 0) begin errors++; $display("FAIL start_held got=%0d exp=0", cnt); end
    done_i = 1'b1;
    @(negedge clk);
    checks++;
    if (start_o !== 1'b0) begin errors++; $display("FAIL start_at_done got=%b exp=0", start_o); end
    tick();
    done_i = 1'b0;
    @(negedge clk);
    checks++;
    if (start_o !== 1'b1) begin errors++; $display("FAIL start_b got=%b exp=1", start_o); end
    tick();
    @(negedge clk);
    checks++;
    if (start_o !== 1'b0) begin errors++; $display("FAIL start_b_once got=%b exp=0", start_o); end
    tick();
    engine_ready_i = 1'b0;
  endtask

  task automatic test_drain;
    logic [RW-1:0] ex;
    logic [AW-1:0] ka [4];
    logic          sa [4];
    ka[0] = AW'(0); ka[1] = AW'(0); ka[2] = AW'(15); ka[3] = AW'(9);
    sa[0] = 1'b1;   sa[1] = 1'b0;   sa[2] = 1'b1;    sa[3] = 1'b0;
    @(negedge clk);
    checks++;
    if (out_avail_o !== 1'b1 || ld_ready_o !== 1'b0) begin errors++; $display("FAIL drain_pre avail=%b ld_ready=%b exp 1/0", out_avail_o, ld_ready_o); end
    tick();
    for (int c = 0; c < 8; c++) begin
      if (c < 4) begin
        out_req_i = 1'b1; out_sel_i = sa[c]; out_addr_i = ka[c]; out_last_i = (c == 3);
        out_q.push_back(sa[c] ? mdl_u[0][ka[c]] : mdl_l[0][ka[c]]);
      end else begin
        out_req_i = 1'b0; out_last_i = 1'b0;
      end
      @(negedge clk);
      if (out_valid_o === 1'b1) begin
        checks++;
        if (out_q.size() == 0) begin errors++; $display("FAIL drain_extra got valid exp none"); end
        else begin
          ex = out_q.pop_front();
          if (out_row_o !== ex) begin errors++; $display("FAIL drain_data got=%h exp=%h", out_row_o[63:0], ex[63:0]); end
        end
      end
      tick();
    end
    checks++;
    if (out_q.size() != 0) begin errors++; $display("FAIL drain_timeout left=%0d exp=0", out_q.size()); end
    out_q.delete();
    @(negedge clk);
    checks++;
    if (out_avail_o !== 1'b0 || ld_ready_o !== 1'b1) begin errors++; $display("FAIL drain_post avail=%b ld_ready=%b exp 0/1", out_avail_o, ld_ready_o); end
    tick();
  endtask

  task automatic test_back_to_back_rdlat3;
    rd_exp_t e;
    int n1, n3;
    n1 = 0; n3 = 0;
    for (int c = 0; c < 10; c++) begin
      if (c < 3) begin
        rd_addr_i = AW'(c); rd_addr_valid_i = 1'b1;
        sb_q.push_back({AW'(c), mdl_mat[1][c]});
        sb3_q.push_back({AW'(c), mdl_mat[1][c]});
      end else begin
        rd_addr_valid_i = 1'b0;
      end
      @(negedge clk);
      if (rd_row_valid_o === 1'b1) begin
        checks++;
        if (sb_q.size() == 0) begin errors++; $display("FAIL b2b_lat1_extra cycle=%0d", c); end
        else begin
          e = sb_q.pop_front();
          if (rd_row_o !== e.row || rd_addr_o !== e.addr || c !== 1 + n1) begin
            errors++; $display("FAIL b2b_lat1 cycle got=%0d exp=%0d addr got=%0d exp=%0d", c, 1 + n1, rd_addr_o, e.addr);
          end
          n1++;
        end
      end
      if (rd_vld3 === 1'b1) begin
        checks++;
        if (sb3_q.size() == 0) begin errors++; $display("FAIL b2b_lat3_extra cycle=%0d", c); end
        else begin
          e = sb3_q.pop_front();
          if (rd_row3 !== e.row || rd_addr3 !== e.addr || c !== 3 + n3) begin
            errors++; $display("FAIL b2b_lat3 cycle got=%0d exp=%0d addr got=%0d exp=%0d row got=%h exp=%h", c, 3 + n3, rd_addr3, e.addr, rd_row3[63:0], e.row[63:0]);
          end
          n3++;
        end
      end
      tick();
    end
    checks++;
    if (sb_q.size() != 0 || sb3_q.size() != 0) begin errors++; $display("FAIL b2b_timeout left1=%0d left3=%0d exp=0", sb_q.size(), sb3_q.size()); end
    sb_q.delete();
    sb3_q.delete();
  endtask

  task automatic test_errors;
    @(negedge clk);
    checks++;
    if (err_o !== 1'b0) begin errors++; $display("FAIL err_clean got=%b exp=0", err_o); end
    tick();
    out_req_i = 1'b1; out_addr_i = AW'(0);
    tick();
    out_req_i = 1'b0;
    @(negedge clk);
    checks++;
    if (err_o !== 1'b1 || out_valid_o !== 1'b0) begin errors++; $display("FAIL err_out_req err=%b valid=%b exp 1/0", err_o, out_valid_o); end
    tick();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    @(negedge clk);
    checks++;
    if (err_o !== 1'b0 || busy_o !== 1'b0 || ld_ready_o !== 1'b1) begin errors++; $display("FAIL flush err=%b busy=%b ld_ready=%b exp 0/0/1", err_o, busy_o, ld_ready_o); end
    tick();
    wr_valid_i = 1'b1; wr_addr_i = AW'(1);
    tick();
    wr_valid_i = 1'b0;
    @(negedge clk);
    checks++;
    if (err_o !== 1'b1) begin errors++; $display("FAIL err_wr_idle got=%b exp=1", err_o); end
    tick();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
  endtask

  task automatic test_single_beat_pivot;
    logic [RW-1:0] row;
    row = make_row(2, 2);
    row[2*2*WIDTH +: 2*WIDTH] = {64'h0, 64'h8000_0000_0000_0000};
    ld_valid_i = 1'b1; ld_last_i = 1'b1; ld_addr_i = AW'(2); ld_row_i = row;
    tick();
    ld_valid_i = 1'b0; ld_last_i = 1'b0;
    @(negedge clk);
    checks++;
    if (busy_o !== 1'b1 || ld_ready_o !== 1'b1 || err_o !== 1'b0) begin errors++; $display("FAIL single_beat busy=%b ld_ready=%b err=%b exp 1/1/0", busy_o, ld_ready_o, err_o); end
`ifdef LU_BANK_PIVOT_CHK_EN
    checks++;
    if (pivot_zero_o !== 1'b1) begin errors++; $display("FAIL pivot_set got=%b exp=1", pivot_zero_o); end
`endif
    tick();
    engine_ready_i = 1'b1;
    @(negedge clk);
    checks++;
    if (start_o !== 1'b1) begin errors++; $display("FAIL single_start got=%b exp=1", start_o); end
    tick();
    engine_ready_i = 1'b0;
    done_i = 1'b1;
    tick();
    done_i = 1'b0;
    @(negedge clk);
    checks++;
    if (out_avail_o !== 1'b1) begin errors++; $display("FAIL single_done avail got=%b exp=1", out_avail_o); end
    tick();
    out_req_i = 1'b1; out_last_i = 1'b1; out_sel_i = 1'b1; out_addr_i = AW'(0);
    tick();
    out_req_i = 1'b0; out_last_i = 1'b0;
    @(negedge clk);
    checks++;
    if (busy_o !== 1'b0 || out_avail_o !== 1'b0) begin errors++; $display("FAIL single_drained busy=%b avail=%b exp 0/0", busy_o, out_avail_o); end
`ifdef LU_BANK_PIVOT_CHK_EN
    checks++;
    if (pivot_zero_o !== 1'b0) begin errors++; $display("FAIL pivot_clear got=%b exp=0", pivot_zero_o); end
`endif
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_load_start();
    test_rw_collision();
    test_second_load();
    test_drain();
    test_back_to_back_rdlat3();
    test_errors();
    test_single_beat_pivot();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lu_mat_bank.md
Name: lu_mat_bank

Overview:
- Multi-bank, row-addressable complex-matrix store that sits between the host and the LU engine.
- Host loads an A matrix row by row. The engine reads and rewrites A rows during elimination, then deposits L columns and U rows. The host drains L/U afterwards.
- With NUM_BANKS=2, the host loads or drains one matrix while the engine works on the other.

Parameters:
- SIZE, 16, matrix dimension; rows per bank; elements per row.
- WIDTH, 64, bits per real/imag component; element = {imag,real} = 2*WIDTH; row = SIZE*2*WIDTH.
- NUM_BANKS, 2, matrix banks (1 or 2 legal; other values fail elaboration).
- RD_LAT, 1, read latency in cycles for the engine and drain read ports (>=1).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- flush_i  in  1  synchronous abort: all banks EMPTY, pointers 0, read pipes cleared
- ld_row_i  in  SIZE*2*WIDTH  host load row
- ld_addr_i  in  clog2(SIZE)  host load row address
- ld_valid_i  in  1  host load valid
- ld_last_i  in  1  final row of matrix (qualified by ld_valid_i & ld_ready_o)
- ld_ready_o  out  1  load bank is EMPTY or LOADING
- start_o  out  1  one-cycle engine start pulse
- engine_ready_i  in  1  engine idle (engine in_ready)
- done_i  in  1  engine finished current matrix
- rd_addr_i  in  clog2(SIZE)  engine A-row read address
- rd_addr_valid_i  in  1  engine read request
- rd_row_o  out  SIZE*2*WIDTH  A-row read data
- rd_addr_o  out  clog2(SIZE)  echoed address aligned with rd_row_o
- rd_row_valid_o  out  1  read data valid
- wr_row_i  in  SIZE*2*WIDTH  engine A-row writeback
- wr_addr_i  in  clog2(SIZE)  writeback address
- wr_valid_i  in  1  writeback valid
- res_l_col_i  in  SIZE*2*WIDTH  L column k
- res_u_row_i  in  SIZE*2*WIDTH  U row k
- res_addr_i  in  clog2(SIZE)  k
- res_valid_i  in  1  result valid
- out_req_i  in  1  drain read request
- out_sel_i  in  1  0 = L column, 1 = U row
- out_addr_i  in  clog2(SIZE)  drain address
- out_last_i  in  1  final drain request for this bank
- out_row_o  out  SIZE*2*WIDTH  drain data
- out_valid_o  out  1  drain data valid
- out_avail_o  out  1  drain bank is DONE
- busy_o  out  1  any bank not EMPTY
- err_o  out  1  sticky protocol error

Behaviour:
- Per-bank state: EMPTY -> LOADING (first load beat) -> FULL (ld_last_i) -> BUSY (start_o issued) -> DONE (done_i) -> EMPTY (accepted out_last_i request).
  - A single-beat load with ld_last_i goes EMPTY -> FULL directly.
- Three pointers (load, engine, drain), each initialised to 0 and advancing modulo NUM_BANKS on its own terminal event.
- start_o is asserted for one cycle when the engine bank is FULL, engine_ready_i=1, and no bank is BUSY. The bank becomes BUSY on the next edge.
- Engine reads and writes, and res_valid_i, always address the BUSY bank.
  - Reads are pipelined: one request per cycle, data arrives after RD_LAT cycles.
  - A read and a write to the same address in the same cycle return the old data.
- Drain reads use the DONE drain bank with the same RD_LAT timing. An out_req_i while out_avail_o=0 is ignored and sets err_o.
- err_o is also set by: wr_valid_i, res_valid_i, or done_i with no BUSY bank; ld_valid_i while ld_ready_o=0. Offending writes are dropped.
- Simultaneous terminal events on different banks are all honoured in the same cycle.
- Reset values: all outputs 0, all banks EMPTY, pointers 0. ld_ready_o rises the cycle after reset release.
- Reset or flush mid-operation discards in-flight read data; storage contents are not cleared. flush_i clears err_o.
- Storage for mat, L and U is register or inferred-RAM arrays indexed by [bank][row].

Optional Feature:
- LU_BANK_PIVOT_CHK_EN.
- Defined:
  - Each accepted load beat compares element ld_addr_i of ld_row_i against zero, ignoring the sign bits of both components.
  - A zero diagonal sets a per-bank sticky pivot flag, exported as output pivot_zero_o (1 bit, engine bank's flag). It is cleared when that bank returns to EMPTY.
  - If the flag is set, start_o is still issued.
- Undefined: the port is absent and no comparator logic is generated.

Decomposition:
- Package lu_pkg holds:
  - bank_state_e (EMPTY, LOADING, FULL, BUSY, DONE);
  - cplx_t struct {imag, real}, each [WIDTH-1:0];
  - the row_t width macro;
  - ROW_W, ADDR_W.
- Sub-module lu_rd_pipe: RD_LAT-deep valid/address/data delay line, instantiated twice (engine port and drain port).

Test Plan:
- NUM_BANKS=2, RD_LAT=1: load 16 rows with ld_last_i on row 15 -> start_o pulses exactly once; reading address 3 returns the loaded row 3 with rd_addr_o=3 one cycle later.
- Engine writes row 5 = 0xA5 pattern while reading row 5 in the same cycle -> read returns the old data; the next read returns 0xA5.
- Load matrix B while bank 0 is BUSY -> ld_ready_o stays 1; start_o for B is delayed until done_i plus engine_ready_i, then fires for bank 1.
- RD_LAT=3, back-to-back reads of addresses 0,1,2 -> rd_row_valid_o is high for 3 consecutive cycles starting 3 cycles after the first request, in order.
- Drain with out_last_i -> bank returns to EMPTY and ld_ready_o reasserts. out_req_i when no bank is DONE -> err_o=1; flush_i -> err_o=0 and busy_o=0.
- LU_BANK_PIVOT_CHK_EN: load row 2 with element 2 = -0.0 + j0.0 -> pivot_zero_o=1 after ld_last_i; it clears after the bank drains.
